// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared types and constants for the issue scoreboard
package id_pkg;
  localparam int MD_LAT_DEFAULT = 32;
  localparam int REG_W          = 5;
  localparam int NREG           = 1 << REG_W;

  typedef enum logic [1:0] {
    IDLE,
    MD_RUN,
    MD_WAIT
  } md_state_t;
endpackage

// File: rtl/id_md_seq.sv
// rtl/id_md_seq.sv - mul/div latency sequencer and register-file write-port arbiter
module id_md_seq
  import id_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REG_W-1:0] start_rd,
  input  logic             wb_valid,
  output logic             md_busy,
  output logic             md_done,
  output logic [REG_W-1:0] md_rd
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

  md_state_t        state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [REG_W-1:0] md_rd_next;

  // Pipeline writeback always owns the port; the result waits for a free cycle.
  assign md_done = !wb_valid &&
                   ((state == MD_RUN && cnt == '0) || state == MD_WAIT);
  assign md_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      md_rd <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      md_rd <= md_rd_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    md_rd_next = md_rd;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = MD_RUN;
          cnt_next   = CNT_LOAD;
          md_rd_next = start_rd;
        end
      end
      MD_RUN: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else if (wb_valid) begin
          state_next = MD_WAIT;
        end
      end
      MD_WAIT: state_next = MD_WAIT;
      default: state_next = IDLE;
    endcase
    // A new op may take the unit in the very cycle the previous result retires.
    if (md_done) begin
      if (start) begin
        state_next = MD_RUN;
        cnt_next   = CNT_LOAD;
        md_rd_next = start_rd;
      end else begin
        state_next = IDLE;
      end
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - register scoreboard with RAW/WAW/structural stall generation
module id_scoreboard
  import id_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             rd_wr,
  input  logic             is_md,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  output logic             stall,
  output logic             issue,
  output logic             md_busy,
  output logic             md_done,
  output logic [REG_W-1:0] md_rd,
  output logic [NREG-1:0]  pending
);

  logic [NREG-1:0]  clr_mask, set_mask, pend_eff, pend_next;
  logic             raw, waw, structural;
  logic             md_start;
  logic [REG_W-1:0] md_start_rd;

  // Writebacks retiring this cycle already count as resolved for hazard checks.
  always_comb begin
    clr_mask = '0;
    if (wb_valid) clr_mask[wb_rd] = 1'b1;
    if (md_done)  clr_mask[md_rd] = 1'b1;
    pend_eff = pending & ~clr_mask;

    raw = (use_rs1 && rs1 != '0 && pend_eff[rs1]) ||
          (use_rs2 && rs2 != '0 && pend_eff[rs2]);
    waw = rd_wr && rd != '0 && pend_eff[rd];
    structural = is_md && md_busy && !md_done;

    stall = id_valid && (raw || waw || structural);
    issue = id_valid && !stall;

    set_mask = '0;
    if (issue && rd_wr && rd != '0) set_mask[rd] = 1'b1;
    pend_next    = pend_eff | set_mask;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pend_next;
  end

  assign md_start    = issue && is_md;
  assign md_start_rd = rd_wr ? rd : '0;

  id_md_seq #(.MD_LAT(MD_LAT)) u_md_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .start_rd (md_start_rd),
    .wb_valid (wb_valid),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .md_rd    (md_rd)
  );

endmodule
